// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master: accepts one command, runs SETUP/ACCESS with a
// pready wait-state timeout, then holds the response until it is consumed.
module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB side
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_e                state_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]           pwdata_q;
  logic                  rsp_valid_q;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_timeout_q;
  logic [7:0]            wait_cnt_q;
  logic                  timeout_hit;

  // Counter holds the number of pready-low ACCESS cycles already seen, so the
  // abort fires in the ACCESS cycle after TIMEOUT_CYCLES low cycles.
  assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LIM);

  // NOTE: every register, including the captured address/data, is cleared by the
  // asynchronous reset so APB outputs are defined the instant presetn falls.
  // NOTE: sequential state uses non-blocking assignments only, so the order of
  // statements inside this block never changes what the next state is.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q   <= cmd_write;
            paddr_q    <= cmd_addr;
            pwdata_q   <= cmd_wdata;
            psel_q     <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          // pready wins over a timeout reached in the same cycle.
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? 32'h0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Cycle-exact bench for apb_cmd_master: a task-driven APB slave model plus a
// response scoreboard, with TIMEOUT_CYCLES=4 so timeout boundaries are reachable.
module tb_apb_cmd_master;

  localparam int AW  = 12;
  localparam int TMO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          busy;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  apb_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"},    psel,        1'b0);
    check({tag, "_penable"}, penable,     1'b0);
    check({tag, "_pwrite"},  pwrite,      1'b0);
    check({tag, "_paddr"},   paddr,       '0);
    check({tag, "_pwdata"},  pwdata,      32'h0);
    check({tag, "_rvalid"},  rsp_valid,   1'b0);
    check({tag, "_rdata"},   rsp_rdata,   32'h0);
    check({tag, "_rerr"},    rsp_err,     1'b0);
    check({tag, "_rtmo"},    rsp_timeout, 1'b0);
    check({tag, "_busy"},    busy,        1'b0);
  endtask

  // One full transfer. waits = pready-low ACCESS cycles the slave inserts; more
  // than TMO means the master must abort in ACCESS cycle TMO+1.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits, input bit slverr,
                         input int hold);
    rsp_t e;
    bit   abort;
    int   n_end;
    abort   = (waits > TMO);
    n_end   = abort ? TMO : waits;
    e.rdata = (wr || abort) ? 32'h0 : rdata;
    e.err   = abort || slverr;
    e.tmo   = abort;

    check("idle_cmd_ready", cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    exp_q.push_back(e);
    tick();
    // Scramble the command inputs to prove the APB fields were latched.
    cmd_valid = 1'b0;
    cmd_write = ~wr;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;

    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, addr);
    check("setup_pwdata", pwdata, wdata);
    check("setup_pwrite", pwrite, wr);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    check("setup_rsp_valid", rsp_valid, 1'b0);
    check("setup_busy", busy, 1'b1);
    tick();

    for (int n = 0; n <= n_end; n++) begin
      check("access_psel", psel, 1'b1);
      check("access_penable", penable, 1'b1);
      check("access_paddr", paddr, addr);
      check("access_pwdata", pwdata, wdata);
      check("access_pwrite", pwrite, wr);
      check("access_rsp_valid", rsp_valid, 1'b0);
      if (n == waits) begin
        pready  = 1'b1;
        prdata  = rdata;
        pslverr = slverr;
      end else begin
        prdata  = 32'hBAD0_0000 | 32'(n);
        pslverr = 1'b1;
      end
      tick();
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h5555_AAAA;
    end

    check("resp_psel", psel, 1'b0);
    check("resp_penable", penable, 1'b0);
    check("resp_paddr_hold", paddr, addr);
    check("resp_cmd_ready", cmd_ready, 1'b0);
    check("resp_valid", rsp_valid, 1'b1);
    check("sb_nonempty", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("resp_rdata", rsp_rdata, e.rdata);
      check("resp_err", rsp_err, e.err);
      check("resp_timeout", rsp_timeout, e.tmo);
    end

    cmd_valid = (hold > 0);
    cmd_write = 1'b1;
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_psel", psel, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rdata", rsp_rdata, e.rdata);
      check("bp_err", rsp_err, e.err);
      check("bp_timeout", rsp_timeout, e.tmo);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
    check("post_psel", psel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    #12;
    check_reset_outputs("rst");
    check("rst_cmd_ready", cmd_ready, 1'b1);
    @(negedge pclk);
    presetn = 1'b1;
    tick();

    // Zero-wait write, 2-wait read, slave error.
    run_txn(1'b1, 12'h008, 32'h0000_1234, 32'h0, 0, 1'b0, 0);
    run_txn(1'b0, 12'h004, 32'h0, 32'hDEAD_BEEF, 2, 1'b0, 0);
    run_txn(1'b1, 12'h010, 32'hA5A5_0001, 32'h0, 0, 1'b1, 0);
    // Timeout abort, and pready arriving exactly on the timeout cycle.
    run_txn(1'b0, 12'h020, 32'h0, 32'h1111_2222, 7, 1'b0, 0);
    run_txn(1'b0, 12'h024, 32'h0, 32'hCAFE_F00D, TMO, 1'b0, 0);
    // Response backpressure, then an immediate follow-on transfer.
    run_txn(1'b0, 12'h030, 32'h0, 32'h0BAD_CAFE, 1, 1'b0, 5);
    run_txn(1'b1, 12'h034, 32'h7777_8888, 32'h0, 0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      run_txn(1'($urandom), AW'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset in the middle of ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'hABC;
    cmd_wdata = 32'hFEED_0001;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_access_penable", penable, 1'b1);
    presetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("async_rst_cmd_ready", cmd_ready, 1'b1);
    #2;
    presetn = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("rel_rsp_valid", rsp_valid, 1'b0);
      check("rel_psel", psel, 1'b0);
      tick();
    end
    run_txn(1'b0, 12'h040, 32'h0, 32'h1357_9BDF, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, APB address width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, range 0..255; maximum ACCESS cycles with pready low before abort; 0 disables the timeout.
REQ-003 SHALL have the following ports. Reset is presetn, asynchronous, active-low; clock is pclk.
- pclk  in  1  clock.
- presetn  in  1  async active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when cmd_valid=1.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready; tie to 1 for slaves without wait states.
- pslverr  in  1  APB error; tie to 0 if unused.
- busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, all registered.
REQ-005 SHALL drive cmd_ready=1 only in IDLE; this output is combinational from state.
REQ-006 In IDLE with cmd_valid=1, SHALL latch cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
REQ-007 In SETUP, SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-008 In ACCESS, SHALL drive psel=1 and penable=1; paddr, pwrite and pwdata SHALL stay stable from SETUP through the end of ACCESS.
REQ-009 In ACCESS with pready=1, SHALL complete the transfer:
- capture rsp_rdata=prdata for reads and 0 for writes;
- set rsp_err=pslverr and rsp_timeout=0;
- go to RESP.
REQ-010 SHALL count ACCESS cycles with pready=0 in an 8-bit counter; the counter clears on entry to SETUP.
REQ-011 When TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES while pready=0, SHALL abort: rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
REQ-012 A pready=1 in the same cycle the timeout condition is reached SHALL take priority; the transfer completes normally.
REQ-013 SHALL drive psel=0 and penable=0 in IDLE and RESP; pwrite, paddr and pwdata SHALL hold their last values.
REQ-014 In RESP, SHALL drive rsp_valid=1 and hold rsp_rdata, rsp_err and rsp_timeout stable until rsp_ready=1, then go to IDLE.
REQ-015 rsp_valid SHALL never be 1 outside RESP; minimum command-to-response latency is 3 cycles (accept, SETUP, ACCESS → RESP).
REQ-016 Back-to-back throughput SHALL be at most one transfer per 4 cycles; no command is accepted while a response is pending.
REQ-017 psel and penable SHALL never be 1 outside SETUP and ACCESS, and penable=1 SHALL never occur without psel=1.

Reset
REQ-018 On presetn=0 the block SHALL go to IDLE immediately, including mid-transfer, and drive:
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
- busy=0, timeout counter=0.
REQ-019 A transfer interrupted by reset SHALL produce no response; cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-020 Write, zero wait: cmd addr=0x008, wdata=0x0000_1234, pready=1 → one SETUP cycle and one ACCESS cycle with paddr=0x008, pwdata=0x1234, pwrite=1; rsp_valid on the 3rd cycle after accept with rsp_err=0.
REQ-021 Read with 2 wait states: cmd read addr=0x004, pready low for 2 ACCESS cycles then high, prdata=0xDEAD_BEEF → penable high for 3 cycles; rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-022 Slave error: write with pslverr=1 at pready=1 → rsp_err=1, rsp_timeout=0.
REQ-023 Timeout: TIMEOUT_CYCLES=4, pready held 0 → abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0, psel drops to 0.
REQ-024 Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready stays 0, rsp fields are stable, no APB activity; a new transfer starts 1 cycle after rsp_ready=1.
REQ-025 Reset mid-ACCESS: presetn=0 while psel=1 and penable=1 → all outputs at their reset values asynchronously; no rsp_valid after release.
